sram_fault_model: RTL and testbench

Parametrised single-port synchronous SRAM behavioural model with a post-reset clear sweep and a programmable fault-injection table. It is the DUT memory for the MBIST controller. It generalises the fixed 64x8 single-port RAM to arbitrary width and depth. It adds injectable stuck-at and transition faults so that march algorithms can be shown to detect them.

---
 rtl/sram_fault_model.sv | 133 +++++++++++++
 tb/tb_sram_fault_model.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sram_fault_model.sv
// Single-port sync SRAM model with post-reset clear sweep and stuck-at / transition fault table.
// Read latency 1 cycle; no backpressure, busy=1 during the sweep means accesses are dropped.
module sram_fault_model #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int NUM_FAULTS = 4,
  parameter int SEL_W      = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
  parameter int BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              rwbar,
  input  logic [ADDR_W-1:0] ramaddr,
  input  logic [DATA_W-1:0] ramin,
  output logic [DATA_W-1:0] ramout,
  output logic              busy,
  input  logic              fi_we,
  input  logic [SEL_W-1:0]  fi_sel,
  input  logic              fi_en,
  input  logic [ADDR_W-1:0] fi_addr,
  input  logic [BIT_W-1:0]  fi_bit,
  input  logic [1:0]        fi_type
);

  localparam int          DEPTH     = 2 ** ADDR_W;
  localparam logic [1:0]  FT_SA0    = 2'b00;
  localparam logic [1:0]  FT_SA1    = 2'b01;
  localparam logic [1:0]  FT_TF_UP  = 2'b10;
  localparam logic [1:0]  FT_TF_DN  = 2'b11;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ramout;
  logic              r_busy;
  logic [ADDR_W-1:0] r_sweep_addr;

  logic              r_fi_en   [NUM_FAULTS];
  logic [ADDR_W-1:0] r_fi_addr [NUM_FAULTS];
  logic [BIT_W-1:0]  r_fi_bit  [NUM_FAULTS];
  logic [1:0]        r_fi_type [NUM_FAULTS];

  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_new;
  logic [DATA_W-1:0] w_wr_old;
  logic [DATA_W-1:0] w_wr_word;
  logic [DATA_W-1:0] w_rd_raw;
  logic [DATA_W-1:0] w_rd_word;

  // The sweep borrows the normal write path so that stuck-at cells come out of clear already faulted.
  assign w_wr_en   = r_busy | (cs & ~rwbar);
  assign w_wr_addr = r_busy ? r_sweep_addr : ramaddr;
  assign w_wr_new  = r_busy ? '0 : ramin;
  assign w_wr_old  = r_mem[w_wr_addr];
  assign w_rd_raw  = r_mem[ramaddr];

  // Slots scanned high to low so the lowest matching index has the final say on each bit.
  always_comb begin
    w_wr_word = w_wr_new;
    for (int b = 0; b < DATA_W; b++) begin
      for (int s = NUM_FAULTS - 1; s >= 0; s--) begin
        if (r_fi_en[s] && (r_fi_addr[s] == w_wr_addr) && (r_fi_bit[s] == BIT_W'(b))) begin
          case (r_fi_type[s])
            FT_SA0:   w_wr_word[b] = 1'b0;
            FT_SA1:   w_wr_word[b] = 1'b1;
            FT_TF_UP: w_wr_word[b] = w_wr_old[b] & w_wr_new[b];
            FT_TF_DN: w_wr_word[b] = w_wr_old[b] | w_wr_new[b];
            default:  w_wr_word[b] = w_wr_new[b];
          endcase
        end
      end
    end
  end

  always_comb begin
    w_rd_word = w_rd_raw;
    for (int b = 0; b < DATA_W; b++) begin
      for (int s = NUM_FAULTS - 1; s >= 0; s--) begin
        if (r_fi_en[s] && (r_fi_addr[s] == ramaddr) && (r_fi_bit[s] == BIT_W'(b))) begin
          case (r_fi_type[s])
            FT_SA0:  w_rd_word[b] = 1'b0;
            FT_SA1:  w_rd_word[b] = 1'b1;
            default: w_rd_word[b] = w_rd_raw[b];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b1;
      r_sweep_addr <= '0;
      r_ramout     <= '0;
    end else if (r_busy) begin
      r_ramout     <= '0;
      r_sweep_addr <= r_sweep_addr + 1'b1;
      if (r_sweep_addr == ADDR_W'(DEPTH - 1)) begin
        r_busy <= 1'b0;
      end
    end else if (cs && rwbar) begin
      r_ramout <= w_rd_word;
    end else if (!cs) begin
      r_ramout <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_FAULTS; s++) begin
        r_fi_en[s]   <= 1'b0;
        r_fi_addr[s] <= '0;
        r_fi_bit[s]  <= '0;
        r_fi_type[s] <= '0;
      end
    end else if (fi_we && (int'(fi_sel) < NUM_FAULTS)) begin
      r_fi_en[fi_sel]   <= fi_en;
      r_fi_addr[fi_sel] <= fi_addr;
      r_fi_bit[fi_sel]  <= fi_bit;
      r_fi_type[fi_sel] <= fi_type;
    end
  end

  assign ramout = r_ramout;
  assign busy   = r_busy;

endmodule

// File: tb/tb_sram_fault_model.sv
// Directed bench for sram_fault_model: sweep timing, plain access, SA/TF faults, slot priority, reset abort.
module tb_sram_fault_model;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic       rwbar;
  logic [5:0] ramaddr;
  logic [7:0] ramin;
  logic [7:0] ramout;
  logic       busy;
  logic       fi_we;
  logic [1:0] fi_sel;
  logic       fi_en;
  logic [5:0] fi_addr;
  logic [2:0] fi_bit;
  logic [1:0] fi_type;

  int checks = 0;
  int errors = 0;

  sram_fault_model dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (cs),
    .rwbar   (rwbar),
    .ramaddr (ramaddr),
    .ramin   (ramin),
    .ramout  (ramout),
    .busy    (busy),
    .fi_we   (fi_we),
    .fi_sel  (fi_sel),
    .fi_en   (fi_en),
    .fi_addr (fi_addr),
    .fi_bit  (fi_bit),
    .fi_type (fi_type)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [1:0] sel, input logic en, input logic [5:0] a,
                      input logic [2:0] b, input logic [1:0] t);
    fi_we = 1'b1; fi_sel = sel; fi_en = en; fi_addr = a; fi_bit = b; fi_type = t;
    cs = 1'b0;
    tick();
    fi_we = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    cs = 1'b1; rwbar = 1'b0; ramaddr = a; ramin = d;
    tick();
    cs = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    cs = 1'b1; rwbar = 1'b1; ramaddr = a;
    tick();
    cs = 1'b0;
  endtask

  // Counts edges until busy drops, while hammering writes that must be ignored.
  task automatic sweep_len(output int n, output int nz);
    n = 0; nz = 0;
    while (busy && n < 200) begin
      cs = 1'b1; rwbar = 1'b0; ramaddr = 6'd10; ramin = 8'hFF;
      tick();
      fi_we = 1'b0;
      if (ramout !== 8'h00) nz++;
      n++;
    end
    cs = 1'b0;
  endtask

  int n;
  int nz;

  initial begin
    rst_n = 1'b0; cs = 1'b0; rwbar = 1'b1; ramaddr = '0; ramin = '0;
    fi_we = 1'b0; fi_sel = '0; fi_en = 1'b0; fi_addr = '0; fi_bit = '0; fi_type = '0;
    #22;
    chk("reset_ramout", 32'(ramout), 32'h00);
    chk("reset_busy", 32'(busy), 32'h1);

    // Release and program slot 0 = SA1 @ addr 3 bit 0 on the first sweep edge.
    rst_n = 1'b1;
    fi_we = 1'b1; fi_sel = 2'd0; fi_en = 1'b1; fi_addr = 6'd3; fi_bit = 3'd0; fi_type = 2'b01;
    sweep_len(n, nz);
    chk("sweep_len", 32'(n), 32'd64);
    chk("sweep_ramout_zero", 32'(nz), 32'd0);
    chk("ready_busy", 32'(busy), 32'h0);

    for (int a = 0; a < 64; a++) begin
      rd(6'(a));
      chk($sformatf("clear_rd_%0d", a), 32'(ramout), (a == 3) ? 32'h01 : 32'h00);
    end

    wr(6'd10, 8'hA5);
    rd(6'd10);
    chk("rd_a5", 32'(ramout), 32'hA5);
    wr(6'd11, 8'h33);
    chk("hold_on_write", 32'(ramout), 32'hA5);
    tick();
    chk("cs_low_zero", 32'(ramout), 32'h00);
    rd(6'd11);
    chk("rd_33", 32'(ramout), 32'h33);

    wr(6'd3, 8'h00);
    rd(6'd3);
    chk("sa1_bit0", 32'(ramout), 32'h01);
    prog(2'd0, 1'b1, 6'd3, 3'd7, 2'b00);
    wr(6'd3, 8'hFF);
    rd(6'd3);
    chk("sa0_bit7", 32'(ramout), 32'h7F);

    prog(2'd1, 1'b1, 6'd20, 3'd2, 2'b10);
    wr(6'd20, 8'h00);
    wr(6'd20, 8'hFF);
    rd(6'd20);
    chk("tf_up", 32'(ramout), 32'hFB);

    wr(6'd21, 8'hFF);
    prog(2'd2, 1'b1, 6'd21, 3'd4, 2'b11);
    wr(6'd21, 8'h00);
    rd(6'd21);
    chk("tf_down", 32'(ramout), 32'h10);

    prog(2'd0, 1'b1, 6'd5, 3'd1, 2'b00);
    prog(2'd1, 1'b1, 6'd5, 3'd1, 2'b01);
    wr(6'd5, 8'hFF);
    rd(6'd5);
    chk("priority_low_slot", 32'(ramout), 32'hFD);

    // Same-edge: the write sees the old table, the read after it sees SA0.
    fi_we = 1'b1; fi_sel = 2'd3; fi_en = 1'b1; fi_addr = 6'd6; fi_bit = 3'd0; fi_type = 2'b00;
    wr(6'd6, 8'hFF);
    fi_we = 1'b0;
    rd(6'd6);
    chk("same_edge_rd_forced", 32'(ramout), 32'hFE);
    prog(2'd3, 1'b0, 6'd6, 3'd0, 2'b00);
    rd(6'd6);
    chk("same_edge_stored", 32'(ramout), 32'hFF);

    // Reset from READY with nonzero ramout, then abort a sweep at cycle 30.
    rst_n = 1'b0;
    #1;
    chk("async_rst_ramout", 32'(ramout), 32'h00);
    chk("async_rst_busy", 32'(busy), 32'h1);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("busy_at_30", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midsweep_rst_busy", 32'(busy), 32'h1);
    chk("midsweep_rst_ramout", 32'(ramout), 32'h00);
    #1;
    rst_n = 1'b1;
    sweep_len(n, nz);
    chk("restart_sweep_len", 32'(n), 32'd64);
    chk("restart_ramout_zero", 32'(nz), 32'd0);

    wr(6'd3, 8'hFF);
    rd(6'd3);
    chk("slots_cleared_a3", 32'(ramout), 32'hFF);
    wr(6'd5, 8'hFF);
    rd(6'd5);
    chk("slots_cleared_a5", 32'(ramout), 32'hFF);
    rd(6'd10);
    chk("restart_cleared_a10", 32'(ramout), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
